// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP add/subtract unit.
// Carries the input operand pair with its valid/ready and the result with its valid/ready.
// master drives operands and result-ready; slave (the unit) drives in_rdy and the result.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_res;
  logic         out_nan;
  logic         out_ofl;

  modport master (
    output in_vld, in_a, in_b, in_sub, out_rdy,
    input  in_rdy, out_vld, out_res, out_nan, out_ofl
  );

  modport slave (
    input  in_vld, in_a, in_b, in_sub, out_rdy,
    output in_rdy, out_vld, out_res, out_nan, out_ofl
  );
endinterface

// File: rtl/fp_addsub_pipe.sv
// Purpose: parametrised 3-stage FP add/subtract (S1 align, S2 add, S3 normalise/pack) with NaN/overflow flags.
// Latency: 3 cycles, 1 op/cycle; optional round-to-nearest-even when FP_ADDSUB_RNE_EN is defined (else truncation).
// Backpressure: global stall when out_vld & ~out_rdy; every stage holds and in_rdy drops.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst,
  fp_addsub_pipe_if.slave bus
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;  // hidden + mantissa + guard/round/sticky
  localparam int AW = MAN_W + 5;  // SW plus carry-out
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_ADDSUB_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  function automatic logic [31:0] f_lzc(input logic [SW-1:0] v);
    logic [31:0] n;
    logic        found;
    n     = 32'(SW);
    found = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 32'(SW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // pipeline registers
  logic             r1_vld, r2_vld, r3_vld;
  logic             r1_sx, r1_sy, r1_spec, r1_nan;
  logic [EXP_W-1:0] r1_ex;
  logic [SW-1:0]    r1_sigx, r1_sigy;
  logic [W-1:0]     r1_sres;
  logic             r2_sign, r2_spec, r2_nan;
  logic [EXP_W-1:0] r2_ex;
  logic [AW-1:0]    r2_sum;
  logic [W-1:0]     r2_sres;
  logic [W-1:0]     r3_res;
  logic             r3_nan, r3_ofl;

  logic w_stall;
  assign w_stall     = r3_vld & ~bus.out_rdy;
  assign bus.in_rdy  = ~w_stall;
  assign bus.out_vld = r3_vld;
  assign bus.out_res = r3_res;
  assign bus.out_nan = r3_nan;
  assign bus.out_ofl = r3_ofl;

  // ---------------- S1: unpack, classify specials, align ----------------
  logic             w_sa, w_sb, w_a_inf, w_b_inf, w_a_nan, w_b_nan, w_a_zero, w_b_zero;
  logic [EXP_W-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff, w_ex, w_ey, w_diff;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic [SW-1:0]    w_siga, w_sigb, w_sigx, w_sigy, w_sh, w_sigy_al;
  logic             w_sx, w_sy, w_lost, w_nan1, w_spec1;
  logic [W-1:0]     w_sres1;

  // Classify operands, pick the larger-exponent operand and shift the other into GRS range.
  always_comb begin
    w_sa     = bus.in_a[W-1];
    w_sb     = bus.in_b[W-1] ^ bus.in_sub;
    w_ea     = bus.in_a[W-2:MAN_W];
    w_eb     = bus.in_b[W-2:MAN_W];
    w_ma     = bus.in_a[MAN_W-1:0];
    w_mb     = bus.in_b[MAN_W-1:0];
    w_a_inf  = (&w_ea) & ~(|w_ma);
    w_b_inf  = (&w_eb) & ~(|w_mb);
    w_a_nan  = (&w_ea) & (|w_ma);
    w_b_nan  = (&w_eb) & (|w_mb);
    w_a_zero = ~(|w_ea) & ~(|w_ma);
    w_b_zero = ~(|w_eb) & ~(|w_mb);
    w_ea_eff = (|w_ea) ? w_ea : EXP_W'(1);
    w_eb_eff = (|w_eb) ? w_eb : EXP_W'(1);
    w_siga   = {|w_ea, w_ma, 3'b000};
    w_sigb   = {|w_eb, w_mb, 3'b000};
    if (w_ea_eff >= w_eb_eff) begin
      w_sx = w_sa;  w_ex = w_ea_eff; w_sigx = w_siga;
      w_sy = w_sb;  w_ey = w_eb_eff; w_sigy = w_sigb;
    end else begin
      w_sx = w_sb;  w_ex = w_eb_eff; w_sigx = w_sigb;
      w_sy = w_sa;  w_ey = w_ea_eff; w_sigy = w_siga;
    end
    w_diff = w_ex - w_ey;
    w_sh   = w_sigy >> w_diff;
    w_lost = |(w_sigy & ~({SW{1'b1}} << w_diff));
    if (32'(w_diff) >= 32'(MAN_W + 3)) begin
      w_sigy_al = {{(SW-1){1'b0}}, |w_sigy};
    end else begin
      w_sigy_al = {w_sh[SW-1:1], w_sh[0] | w_lost};
    end

    // Specials bypass the datapath; NaN beats inf beats zero.
    w_nan1  = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    w_spec1 = w_nan1 | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
    if (w_nan1)                  w_sres1 = QNAN;
    else if (w_a_inf)            w_sres1 = {w_sa, EMAX, {MAN_W{1'b0}}};
    else if (w_b_inf)            w_sres1 = {w_sb, EMAX, {MAN_W{1'b0}}};
    else if (w_a_zero & w_b_zero) w_sres1 = {w_sa & w_sb, {(W-1){1'b0}}};
    else if (w_a_zero)           w_sres1 = {w_sb, w_eb, w_mb};
    else                         w_sres1 = bus.in_a;
  end

  // Stage valids advance together unless the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_vld <= 1'b0;
      r2_vld <= 1'b0;
      r3_vld <= 1'b0;
    end else if (!w_stall) begin
      r1_vld <= bus.in_vld;
      r2_vld <= r1_vld;
      r3_vld <= r2_vld;
    end
  end

  // S1 data register loads only on an accepted operand pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_sx   <= 1'b0;
      r1_sy   <= 1'b0;
      r1_ex   <= '0;
      r1_sigx <= '0;
      r1_sigy <= '0;
      r1_spec <= 1'b0;
      r1_nan  <= 1'b0;
      r1_sres <= '0;
    end else if (!w_stall && bus.in_vld) begin
      r1_sx   <= w_sx;
      r1_sy   <= w_sy;
      r1_ex   <= w_ex;
      r1_sigx <= w_sigx;
      r1_sigy <= w_sigy_al;
      r1_spec <= w_spec1;
      r1_nan  <= w_nan1;
      r1_sres <= w_sres1;
    end
  end

  // ---------------- S2: signed-magnitude add ----------------
  logic [AW-1:0] w_sum;
  logic          w_sign2;

  // Larger magnitude sets the sign; an exact zero is +0 (-0 + -0 is a special).
  always_comb begin
    if (r1_sx == r1_sy) begin
      w_sum   = {1'b0, r1_sigx} + {1'b0, r1_sigy};
      w_sign2 = r1_sx;
    end else if (r1_sigx >= r1_sigy) begin
      w_sum   = {1'b0, r1_sigx} - {1'b0, r1_sigy};
      w_sign2 = r1_sx;
    end else begin
      w_sum   = {1'b0, r1_sigy} - {1'b0, r1_sigx};
      w_sign2 = r1_sy;
    end
    if (w_sum == '0) w_sign2 = 1'b0;
  end

  // S2 data register loads when S1 holds a valid op and the pipe moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r2_sign <= 1'b0;
      r2_ex   <= '0;
      r2_sum  <= '0;
      r2_spec <= 1'b0;
      r2_nan  <= 1'b0;
      r2_sres <= '0;
    end else if (!w_stall && r1_vld) begin
      r2_sign <= w_sign2;
      r2_ex   <= r1_ex;
      r2_sum  <= w_sum;
      r2_spec <= r1_spec;
      r2_nan  <= r1_nan;
      r2_sres <= r1_sres;
    end
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [SW-1:0]    w_norm;
  logic [EXP_W:0]   w_exp_n, w_exp_r;
  logic [31:0]      w_lz, w_lim, w_shamt;
  logic             w_rup, w_hid, w_ofl3;
  logic [MAN_W+1:0] w_sig_r;
  logic [MAN_W-1:0] w_man;
  logic [W-1:0]     w_res3;

  // Carry shifts right; otherwise shift left but never below exponent 1 (denormal floor).
  always_comb begin
    w_lz    = f_lzc(r2_sum[SW-1:0]);
    w_lim   = 32'(r2_ex) - 32'd1;
    w_shamt = '0;
    if (r2_sum[AW-1]) begin
      w_norm  = {r2_sum[AW-1:2], r2_sum[1] | r2_sum[0]};
      w_exp_n = {1'b0, r2_ex} + (EXP_W+1)'(1);
    end else begin
      w_shamt = (w_lz < w_lim) ? w_lz : w_lim;
      w_norm  = r2_sum[SW-1:0] << w_shamt;
      w_exp_n = {1'b0, r2_ex} - (EXP_W+1)'(w_shamt);
    end

    // Round-to-nearest-even on guard with round|sticky|lsb as tie breaker.
    w_rup   = RNE & w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    w_sig_r = {1'b0, w_norm[SW-1:3]} + (MAN_W+2)'(w_rup);
    if (w_sig_r[MAN_W+1]) begin
      w_exp_r = w_exp_n + (EXP_W+1)'(1);
      w_man   = w_sig_r[MAN_W:1];
      w_hid   = 1'b1;
    end else begin
      w_exp_r = w_exp_n;
      w_man   = w_sig_r[MAN_W-1:0];
      w_hid   = w_sig_r[MAN_W];
    end

    w_ofl3 = (w_exp_r >= {1'b0, EMAX});
    if (w_ofl3) begin
      w_res3 = {r2_sign, EMAX, {MAN_W{1'b0}}};
    end else begin
      w_res3 = {r2_sign, (w_hid ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_man};
    end
  end

  // Output register loads when S2 holds a valid op; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r3_res <= '0;
      r3_nan <= 1'b0;
      r3_ofl <= 1'b0;
    end else if (!w_stall && r2_vld) begin
      if (r2_spec) begin
        r3_res <= r2_sres;
        r3_nan <= r2_nan;
        r3_ofl <= 1'b0;
      end else begin
        r3_res <= w_res3;
        r3_nan <= 1'b0;
        r3_ofl <= w_ofl3;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe (EXP_W=8, MAN_W=23): directed vectors with hand-computed results.
// Driver pushes expectations on acceptance; a negedge monitor pops and compares on each transfer.
// Also checks latency, stall hold, in_rdy under stall and async reset mid-flight.
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp_addsub_pipe_if #(.EXP_W(8), .MAN_W(23)) bus();
  fp_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] res;
    logic        nan;
    logic        ofl;
    int          icyc;
    bit          lat;
    int          id;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_hold = 0;
  int   cyc    = 0;
  int   next_id = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Monitor: compare each transferred result, and check hold/in_rdy while stalled.
  logic [31:0] held_res;
  logic        held_nan, held_ofl;
  bit          held_v = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 0;
    end else begin
      if (held_v) begin
        n_hold++;
        check(bus.out_vld && bus.out_res == held_res && bus.out_nan == held_nan && bus.out_ofl == held_ofl,
              "hold_stable", bus.out_res, held_res);
      end
      held_v = 0;
      if (bus.out_vld) begin
        if (!bus.out_rdy) begin
          check(bus.in_rdy == 1'b0, "in_rdy_stall", 32'(bus.in_rdy), 32'd0);
          held_v   = 1;
          held_res = bus.out_res;
          held_nan = bus.out_nan;
          held_ofl = bus.out_ofl;
        end else if (sb_q.size() == 0) begin
          check(1'b0, "unexpected_out", bus.out_res, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check(bus.out_res == e.res, $sformatf("result#%0d", e.id), bus.out_res, e.res);
          check({bus.out_nan, bus.out_ofl} == {e.nan, e.ofl}, $sformatf("flags#%0d{nan,ofl}", e.id),
                32'({bus.out_nan, bus.out_ofl}), 32'({e.nan, e.ofl}));
          if (e.lat) check(cyc - e.icyc == 3, "latency", 32'(cyc - e.icyc), 32'd3);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1);
  end

  // Present one op at a negedge and hold it until in_rdy is seen; push expectation on acceptance.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                      input logic [31:0] er, input logic en, input logic eo, input bit lat);
    exp_t e;
    int   w;
    w = 0;
    @(negedge clk);
    bus.in_vld = 1'b1;
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_sub = s;
    #1;
    while (!bus.in_rdy && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (!bus.in_rdy) begin
      check(1'b0, "in_rdy_timeout", 32'(bus.in_rdy), 32'd1);
    end else begin
      e.res = er; e.nan = en; e.ofl = eo; e.icyc = cyc; e.lat = lat; e.id = next_id;
      next_id++;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_vld = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(sb_q.size() == 0, "drain", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  int stale;

  initial begin
    rst         = 1'b1;
    bus.in_vld  = 1'b0;
    bus.in_a    = '0;
    bus.in_b    = '0;
    bus.in_sub  = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check({bus.out_vld, bus.out_nan, bus.out_ofl} == 3'b000 && bus.out_res == 32'h0,
          "reset_outputs", bus.out_res, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check(bus.in_rdy == 1'b1, "in_rdy_after_reset", 32'(bus.in_rdy), 32'd1);

    // 1.0 + 1.0 with latency check
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b1);
    idle();
    drain();

    // Four back-to-back ops; consumer stalls 2 cycles once the first result arrives
    fork
      begin
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0); // 2+1
        send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b0, 1'b0); // 1-2
        send(32'h41200000, 32'h40A00000, 1'b1, 32'h40A00000, 1'b0, 1'b0, 1'b0); // 10-5
        send(32'h3F000000, 32'h3E800000, 1'b0, 32'h3F400000, 1'b0, 1'b0, 1'b0); // .5+.25
        idle();
      end
      begin
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1 bus.out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus.out_rdy = 1'b1;
      end
    join
    drain();
    check(n_hold >= 2, "stall_observed", 32'(n_hold), 32'd2);

    // Specials
    send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 1'b1, 1'b0, 1'b0); // inf - inf
    send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0); // overflow
    send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 1'b0, 1'b0, 1'b0); // -inf + 1
    send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b1, 1'b0, 1'b0); // NaN operand
    send(32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b0); // 0 - 2
    send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0); // -0 + -0
    send(32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b0, 1'b0); // inf - (-inf)
    idle();
    drain();

    // Denormals and cancellation
    send(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
    send(32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 1'b0, 1'b0, 1'b0);
    send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b0);
    send(32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // Rounding: above-half and exact tie
`ifdef FP_ADDSUB_RNE_EN
    send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 1'b0, 1'b0, 1'b0);
`else
    send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
`endif
    send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    idle();
    drain();

    // Async reset with three ops in flight
    send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0, 1'b0);
    send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst        = 1'b1;
    bus.in_vld = 1'b0;
    sb_q.delete();
    #1;
    check(bus.out_vld == 1'b0 && bus.out_res == 32'h0, "rst_async_clear", 32'(bus.out_vld), 32'd0);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_vld) stale++;
    end
    check(stale == 0, "no_stale_after_reset", 32'(stale), 32'd0);
    send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b1); // 3+1
    idle();
    drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
